// File: rtl/dbram_tdp.sv
// True dual-port RAM with byte enables, selectable read-during-write result,
// A-wins same-address collision merging, and an optional post-reset zeroing engine.
module dbram_tdp #(
    parameter int data_width     = 16,
    parameter int adr_width      = 10,
    parameter int be_width       = data_width / 8,
    parameter     init_file      = "none",
    parameter int rdw_mode       = 0,
    parameter int clear_on_reset = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_en,
    input  logic [be_width-1:0]   a_we,
    input  logic [adr_width-1:0]  a_a,
    input  logic [data_width-1:0] a_do,
    output logic [data_width-1:0] a_di,
    output logic                  a_valid,

    input  logic                  b_en,
    input  logic [be_width-1:0]   b_we,
    input  logic [adr_width-1:0]  b_a,
    input  logic [data_width-1:0] b_do,
    output logic [data_width-1:0] b_di,
    output logic                  b_valid,

    output logic                  ready,
    output logic                  collision,
    output logic [15:0]           collision_count
);

    localparam int depth     = 1 << adr_width;
    localparam bit use_clear = (clear_on_reset != 0) && (init_file == "none");

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam state_t reset_state = use_clear ? CLEAR : RUN;

    logic [data_width-1:0] ram [depth];

    state_t                 state_reg, state_next;
    logic [adr_width-1:0]   clr_addr_reg, clr_addr_next;
    logic                   clearing;
    logic                   ready_reg;

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        clearing      = 1'b0;
        case (state_reg)
            CLEAR: begin
                clearing      = 1'b1;
                clr_addr_next = clr_addr_reg + 1'b1;
                if (clr_addr_reg == '1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = reset_state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= reset_state;
            clr_addr_reg <= '0;
            ready_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            ready_reg    <= (state_next == RUN);
        end
    end

    // Requests only count once ready has been presented, so the clear engine
    // never competes with a port for the array.
    logic                  a_go, b_go;
    logic                  same_addr;
    logic                  coll_now;
    logic [be_width-1:0]   a_wr_lane, b_wr_lane;
    logic [data_width-1:0] a_old, b_old;
    logic [data_width-1:0] a_new, b_new;

    assign a_go      = a_en & ready_reg;
    assign b_go      = b_en & ready_reg;
    assign same_addr = a_go & b_go & (a_a == b_a);
    assign coll_now  = same_addr & ((|a_we) | (|b_we));
    assign a_old     = ram[a_a];
    assign b_old     = ram[b_a];

    // Per lane: A wins a doubly-written byte; the merged word is what each port
    // sees in write-first mode, regardless of which port wrote it.
    genvar gi;
    generate
        for (gi = 0; gi < be_width; gi++) begin : g_lane
            assign a_wr_lane[gi] = a_go & a_we[gi];
            assign b_wr_lane[gi] = b_go & b_we[gi] & ~(same_addr & a_we[gi]);

            assign a_new[8*gi +: 8] = a_wr_lane[gi]               ? a_do[8*gi +: 8] :
                                      (same_addr & b_wr_lane[gi]) ? b_do[8*gi +: 8] :
                                                                    a_old[8*gi +: 8];
            assign b_new[8*gi +: 8] = b_wr_lane[gi]               ? b_do[8*gi +: 8] :
                                      (same_addr & a_wr_lane[gi]) ? a_do[8*gi +: 8] :
                                                                    b_old[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clearing) begin
            ram[clr_addr_reg] <= '0;
        end
        for (int i = 0; i < be_width; i++) begin
            if (b_wr_lane[i]) begin
                ram[b_a][8*i +: 8] <= b_do[8*i +: 8];
            end
            if (a_wr_lane[i]) begin
                ram[a_a][8*i +: 8] <= a_do[8*i +: 8];
            end
        end
    end

    logic [data_width-1:0] a_di_reg, b_di_reg;
    logic                  a_valid_reg, b_valid_reg;
    logic                  collision_reg;
    logic [15:0]           count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_di_reg      <= '0;
            b_di_reg      <= '0;
            a_valid_reg   <= 1'b0;
            b_valid_reg   <= 1'b0;
            collision_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            a_valid_reg   <= a_go;
            b_valid_reg   <= b_go;
            collision_reg <= coll_now;
            if (a_go) begin
                a_di_reg <= (rdw_mode != 0) ? a_old : a_new;
            end
            if (b_go) begin
                b_di_reg <= (rdw_mode != 0) ? b_old : b_new;
            end
            if (coll_now && (count_reg != 16'hFFFF)) begin
                count_reg <= count_reg + 16'd1;
            end
        end
    end

    assign a_di            = a_di_reg;
    assign b_di            = b_di_reg;
    assign a_valid         = a_valid_reg;
    assign b_valid         = b_valid_reg;
    assign ready           = ready_reg;
    assign collision       = collision_reg;
    assign collision_count = count_reg;

endmodule

// File: tb/tb_dbram_tdp.sv
// Scoreboard bench: two instances (write-first with clear engine, read-first
// without) share stimulus; a negedge monitor pops expected responses per port.
module tb_dbram_tdp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [1:0]  a_we = '0, b_we = '0;
    logic [9:0]  a_a = '0, b_a = '0;
    logic [15:0] a_do = '0, b_do = '0;

    logic [15:0] a_di0, b_di0, a_di1, b_di1;
    logic        a_valid0, b_valid0, a_valid1, b_valid1;
    logic        ready0, ready1, collision0, collision1;
    logic [15:0] count0, count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dbram_tdp #(.data_width(16), .adr_width(10), .rdw_mode(0), .clear_on_reset(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_a(a_a), .a_do(a_do), .a_di(a_di0), .a_valid(a_valid0),
        .b_en(b_en), .b_we(b_we), .b_a(b_a), .b_do(b_do), .b_di(b_di0), .b_valid(b_valid0),
        .ready(ready0), .collision(collision0), .collision_count(count0)
    );

    dbram_tdp #(.data_width(16), .adr_width(10), .rdw_mode(1), .clear_on_reset(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_a(a_a), .a_do(a_do), .a_di(a_di1), .a_valid(a_valid1),
        .b_en(b_en), .b_we(b_we), .b_a(b_a), .b_do(b_do), .b_di(b_di1), .b_valid(b_valid1),
        .ready(ready1), .collision(collision1), .collision_count(count1)
    );

    typedef struct {
        logic [15:0] data;
        bit          chk;
        bit          coll;
        logic [15:0] cnt;
    } exp_t;

    exp_t qa0[$], qb0[$], qa1[$], qb1[$];
    exp_t mon_e;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=valid expected=no_pending_request", nm);
    endtask

    // Monitor: each valid pops the oldest expectation for that port/instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid0) begin
                if (qa0.size() == 0) unexpected("a0_valid");
                else begin
                    mon_e = qa0.pop_front();
                    if (mon_e.chk) cmp("a0_data", a_di0, mon_e.data);
                    cmp("a0_collision", 16'(collision0), 16'(mon_e.coll));
                    cmp("a0_count", count0, mon_e.cnt);
                end
            end
            if (b_valid0) begin
                if (qb0.size() == 0) unexpected("b0_valid");
                else begin
                    mon_e = qb0.pop_front();
                    if (mon_e.chk) cmp("b0_data", b_di0, mon_e.data);
                end
            end
            if (a_valid1) begin
                if (qa1.size() == 0) unexpected("a1_valid");
                else begin
                    mon_e = qa1.pop_front();
                    if (mon_e.chk) cmp("a1_data", a_di1, mon_e.data);
                    cmp("a1_collision", 16'(collision1), 16'(mon_e.coll));
                    cmp("a1_count", count1, mon_e.cnt);
                end
            end
            if (b_valid1) begin
                if (qb1.size() == 0) unexpected("b1_valid");
                else begin
                    mon_e = qb1.pop_front();
                    if (mon_e.chk) cmp("b1_data", b_di1, mon_e.data);
                end
            end
        end
    end

    // Expected data of -1 means "not checked" (contents undefined for that instance).
    task automatic op(input logic ae, input logic [1:0] awe, input logic [9:0] aa, input logic [15:0] ad,
                      input logic be, input logic [1:0] bwe, input logic [9:0] ba, input logic [15:0] bd,
                      input int ea0, input int ea1, input int eb0, input int eb1,
                      input bit ec, input int ecnt);
        exp_t e;
        @(negedge clk);
        a_en = ae; a_we = awe; a_a = aa; a_do = ad;
        b_en = be; b_we = bwe; b_a = ba; b_do = bd;
        $display("op A en=%0d we=%b addr=%0d data=%h | B en=%0d we=%b addr=%0d data=%h",
                 ae, awe, aa, ad, be, bwe, ba, bd);
        e.coll = ec;
        e.cnt  = 16'(ecnt);
        if (ae) begin
            e.chk = (ea0 >= 0); e.data = 16'(ea0); qa0.push_back(e);
            e.chk = (ea1 >= 0); e.data = 16'(ea1); qa1.push_back(e);
        end
        if (be) begin
            e.chk = (eb0 >= 0); e.data = 16'(eb0); qb0.push_back(e);
            e.chk = (eb1 >= 0); e.data = 16'(eb1); qb1.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
    endtask

    task automatic check_reset(input string nm);
        cmp({nm, "_ready0"}, 16'(ready0), 16'd0);
        cmp({nm, "_ready1"}, 16'(ready1), 16'd0);
        cmp({nm, "_a_valid0"}, 16'(a_valid0), 16'd0);
        cmp({nm, "_b_valid0"}, 16'(b_valid0), 16'd0);
        cmp({nm, "_a_di0"}, a_di0, 16'h0000);
        cmp({nm, "_b_di0"}, b_di0, 16'h0000);
        cmp({nm, "_a_di1"}, a_di1, 16'h0000);
        cmp({nm, "_collision0"}, 16'(collision0), 16'd0);
        cmp({nm, "_count0"}, count0, 16'd0);
        cmp({nm, "_count1"}, count1, 16'd0);
    endtask

    // Counts rising edges from release until dut0 reports ready; dut1 has no
    // clear engine and must be ready after the first edge.
    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) cmp({nm, "_ready1_first_edge"}, 16'(ready1), 16'd1);
        end while (!ready0 && n < 2000);
        cmp({nm, "_ready0_cycles"}, 16'(n), 16'd1024);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((qa0.size() + qb0.size() + qa1.size() + qb1.size()) != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        cmp({nm, "_pending"}, 16'(qa0.size() + qb0.size() + qa1.size() + qb1.size()), 16'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("clear1");

        // Cleared memory reads back zero on dut0
        op(1, 2'b00, 10'd100, 16'h0, 1, 2'b00, 10'd1023, 16'h0, 'h0000, -1, 'h0000, -1, 0, 0);
        // Byte enables
        op(1, 2'b11, 10'd5, 16'hBEEF, 0, 2'b00, 10'd0, 16'h0, 'hBEEF, -1, -1, -1, 0, 0);
        op(1, 2'b10, 10'd5, 16'h1234, 0, 2'b00, 10'd0, 16'h0, 'h12EF, 'hBEEF, -1, -1, 0, 0);
        op(1, 2'b00, 10'd5, 16'h0, 0, 2'b00, 10'd0, 16'h0, 'h12EF, 'h12EF, -1, -1, 0, 0);
        // Read-during-write
        op(1, 2'b11, 10'd3, 16'h1111, 0, 2'b00, 10'd0, 16'h0, 'h1111, -1, -1, -1, 0, 0);
        op(1, 2'b11, 10'd3, 16'h2222, 0, 2'b00, 10'd0, 16'h0, 'h2222, 'h1111, -1, -1, 0, 0);
        op(1, 2'b00, 10'd3, 16'h0, 0, 2'b00, 10'd0, 16'h0, 'h2222, 'h2222, -1, -1, 0, 0);
        // Collision: A lane 0, B both lanes -> 0x55AA
        op(1, 2'b01, 10'd7, 16'hAAAA, 1, 2'b11, 10'd7, 16'h5555, 'h55AA, -1, 'h55AA, -1, 1, 1);
        // Same-address reads are not a collision
        op(1, 2'b00, 10'd7, 16'h0, 1, 2'b00, 10'd7, 16'h0, 'h55AA, 'h55AA, 'h55AA, 'h55AA, 0, 1);
        // Independent ports
        op(1, 2'b11, 10'd1, 16'h0101, 1, 2'b11, 10'd2, 16'h0202, 'h0101, -1, 'h0202, -1, 0, 1);
        op(1, 2'b00, 10'd1, 16'h0, 1, 2'b00, 10'd2, 16'h0, 'h0101, 'h0101, 'h0202, 'h0202, 0, 1);
        // Both write lane 1: A wins -> 0x12AA
        op(1, 2'b10, 10'd7, 16'h1234, 1, 2'b10, 10'd7, 16'hABCD, 'h12AA, 'h55AA, 'h12AA, 'h55AA, 1, 2);
        // A reads while B writes lane 0 -> 0x12CD
        op(1, 2'b00, 10'd7, 16'h0, 1, 2'b01, 10'd7, 16'h00CD, 'h12CD, 'h12AA, 'h12CD, 'h12AA, 1, 3);
        op(1, 2'b00, 10'd7, 16'h0, 1, 2'b00, 10'd7, 16'h0, 'h12CD, 'h12CD, 'h12CD, 'h12CD, 0, 3);
        idle();
        drain("run");

        // Read data holds while idle
        @(negedge clk);
        cmp("hold_a_di0", a_di0, 16'h12CD);
        cmp("hold_b_di1", b_di1, 16'h12CD);
        cmp("hold_a_valid0", 16'(a_valid0), 16'd0);

        // Reset mid-RUN, then mid-CLEAR at cycle 100
        rst_n = 1'b0;
        #1;
        check_reset("mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("mid_clear");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("clear2");

        op(1, 2'b00, 10'd1023, 16'h0, 1, 2'b00, 10'd7, 16'h0, 'h0000, -1, 'h0000, -1, 0, 0);
        op(1, 2'b00, 10'd0, 16'h0, 1, 2'b00, 10'd5, 16'h0, 'h0000, -1, 'h0000, -1, 0, 0);
        idle();
        drain("post_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
